// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM encoding and default sizing.
package period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam int DEF_CNT_WIDTH = 16;
    localparam int DEF_TIMEOUT   = 50000;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input, followed by a delay flop
// that turns each synchronized 0->1 transition into a single-cycle rise pulse.
module sync_edge_detect
    import period_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic asyncIn,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic delayed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            delayed <= 1'b0;
        end else begin
            sync_1  <= asyncIn;
            sync_2  <= sync_1;
            delayed <= sync_2;
        end
    end

    assign rise = sync_2 & ~delayed;

endmodule

// File: rtl/period_meter.sv
// Measures the period of a slow external square wave in clk cycles and flags
// loss of signal when no rising edge arrives within TIMEOUT cycles.
//
// state   | meaning
// IDLE    | disabled, counter held at 0
// ARM     | waiting for the first rising edge (reference point)
// MEASURE | counting since the last edge; each new edge reports a period
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sigIn,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 valid,
    output logic                 noSignal
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TO  = CNT_WIDTH'(TIMEOUT);

    logic                 rise;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic                 valid_q, valid_d;
    logic                 no_sig_q, no_sig_d;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst     (rst),
        .asyncIn (sigIn),
        .rise    (rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            no_sig_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            no_sig_q <= no_sig_d;
        end
    end

    // A rise always takes priority over the timeout compare, so a period of
    // exactly TIMEOUT is still a valid measurement and the counter never wraps.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        valid_d  = 1'b0;
        no_sig_d = no_sig_q;
        if (!enable) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            no_sig_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    count_d = CNT_ONE;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_d = ST_MEASURE;
                        count_d = CNT_ONE;
                    end else if (count_q == CNT_TO) begin
                        no_sig_d = 1'b1;
                        count_d  = '0;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        period_d = count_q;
                        valid_d  = 1'b1;
                        no_sig_d = 1'b0;
                        count_d  = CNT_ONE;
                    end else if (count_q == CNT_TO) begin
                        state_d  = ST_ARM;
                        no_sig_d = 1'b1;
                        count_d  = '0;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign period   = period_q;
    assign valid    = valid_q;
    assign noSignal = no_sig_q;

endmodule

// File: tb/tb_period_meter.sv
// Randomized and directed stimulus for period_meter, checked by a timestamp-based
// reference model feeding a scoreboard of expected period reports.
module tb_period_meter;

    localparam int W  = 8;
    localparam int TO = 100;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sig_in = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] period;
    logic         valid;
    logic         no_signal;

    int checks = 0;
    int errors = 0;

    period_meter #(.CNT_WIDTH(W), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .sigIn    (sig_in),
        .enable   (enable),
        .period   (period),
        .valid    (valid),
        .noSignal (no_signal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the sampled input reaches the measuring logic three edges
    // later; elapsed time is measured from the last reference timestamp.
    int  cyc = 0;
    int  base = 0;
    bit  running = 0;
    bit  have_ref = 0;
    bit  m_nosig = 0;
    int  m_period = 0;
    bit  h1 = 0, h2 = 0, h3 = 0;
    int  exp_q[$];
    bit  mon_on = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            running  = 0;
            have_ref = 0;
            m_nosig  = 0;
            m_period = 0;
            h1 = 0; h2 = 0; h3 = 0;
            cyc = 0;
        end else begin
            bit r;
            r = h2 && !h3;
            cyc++;
            if (!enable) begin
                running  = 0;
                have_ref = 0;
                m_nosig  = 0;
            end else if (!running) begin
                running  = 1;
                have_ref = 0;
                base     = cyc;
            end else if (r) begin
                if (have_ref) begin
                    m_period = cyc - base;
                    exp_q.push_back(m_period);
                    m_nosig = 0;
                end
                have_ref = 1;
                base     = cyc;
            end else if (cyc - base == TO) begin
                m_nosig  = 1;
                have_ref = 0;
                base     = cyc + 1;
            end
            h3 = h2; h2 = h1; h1 = sig_in;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid=1 period=%0d expected no valid at %0t", period, $time);
                end else begin
                    check("valid_period", int'(period), exp_q.pop_front());
                    check("nosig_on_valid", int'(no_signal), 0);
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL missed_valid: got valid=0 expected period=%0d at %0t", exp_q[0], $time);
                exp_q.delete();
            end
            check("period_level", int'(period), m_period);
            check("nosig_level", int'(no_signal), int'(m_nosig));
        end
    end

    task automatic wave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            sig_in = ((i % p) < h);
        end
    endtask

    task automatic set_enable(input bit v);
        @(posedge clk);
        #1;
        enable = v;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #3;
        rst = 1'b0;
        sig_in = 1'b0;
        #1;
        check("rst_period", int'(period), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_nosig", int'(no_signal), 0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #12;
        check("init_period", int'(period), 0);
        check("init_valid", int'(valid), 0);
        check("init_nosig", int'(no_signal), 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        mon_on = 1'b1;

        // steady 10-cycle wave
        set_enable(1'b1);
        wave(10, 5, 120);
        @(negedge clk);
        check("p10", int'(period), 10);
        check("p10_nosig", int'(no_signal), 0);

        // disable mid-measurement, then resume
        set_enable(1'b0);
        wave(10, 5, 20);
        @(negedge clk);
        check("idle_hold", int'(period), 10);
        check("idle_valid", int'(valid), 0);
        set_enable(1'b1);
        wave(10, 5, 60);

        // loss of signal, then recovery at period 20
        wave(1, 0, 150);
        @(negedge clk);
        check("timeout_nosig", int'(no_signal), 1);
        wave(20, 10, 100);
        @(negedge clk);
        check("p20", int'(period), 20);
        check("p20_nosig", int'(no_signal), 0);

        // boundary: exactly TIMEOUT, then one beyond
        wave(100, 50, 400);
        @(negedge clk);
        check("p100", int'(period), 100);
        check("p100_nosig", int'(no_signal), 0);
        wave(101, 50, 400);
        @(negedge clk);
        check("p101_nosig", int'(no_signal), 1);
        check("p101_hold", int'(period), 100);

        // period change 10 -> 30
        wave(10, 5, 100);
        wave(30, 15, 150);
        @(negedge clk);
        check("p30", int'(period), 30);

        // asynchronous reset mid-measurement
        wave(7, 3, 40);
        reset_pulse();
        wave(7, 3, 80);
        @(negedge clk);
        check("p7_after_rst", int'(period), 7);

        // randomized periods, duty cycles and enable drops
        for (int k = 0; k < 10; k++) begin
            int p, h;
            p = $urandom_range(110, 3);
            h = $urandom_range(p - 1, 1);
            if ($urandom_range(3, 0) == 0) begin
                set_enable(1'b0);
                wave(p, h, $urandom_range(15, 1));
                set_enable(1'b1);
            end
            wave(p, h, p * $urandom_range(5, 2));
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
